// File: rtl/neuron_sequencer_if.sv
// ---------------------------------------------------------------------------
// neuron_sequencer_if
//
// Bundles the two buses the neuron sequencer talks over:
//   * the shared-neuron control bus (neuron_ready / neuron_result in,
//     neuron_rst / layer_sel / neuron_idx out), and
//   * the result write bus (wr_en / wr_layer / wr_addr / wr_data out).
//
// Parameters
//   n                   width of one neuron result word
//   clog2_size_of_layer width of neuron_idx / wr_addr
//
// Modports
//   master  the sequencer side (drives control and write bus)
//   slave   the neuron / result-memory side
// ---------------------------------------------------------------------------
interface neuron_sequencer_if #(
    parameter int n                   = 8,
    parameter int clog2_size_of_layer = 5
);
    logic                           neuron_ready;
    logic [n-1:0]                   neuron_result;
    logic                           neuron_rst;
    logic                           layer_sel;
    logic [clog2_size_of_layer-1:0] neuron_idx;

    logic                           wr_en;
    logic                           wr_layer;
    logic [clog2_size_of_layer-1:0] wr_addr;
    logic [n-1:0]                   wr_data;

    modport master (
        input  neuron_ready, neuron_result,
        output neuron_rst, layer_sel, neuron_idx,
        output wr_en, wr_layer, wr_addr, wr_data
    );

    modport slave (
        output neuron_ready, neuron_result,
        input  neuron_rst, layer_sel, neuron_idx,
        input  wr_en, wr_layer, wr_addr, wr_data
    );
endinterface

// File: rtl/neuron_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_sequencer
//
// Time-multiplexes one shared neuron over a two-layer network. For every
// neuron it clears the accumulator (LOAD), waits for the neuron to report
// completion (RUN), then writes the captured result (STORE). It walks all
// hidden-layer neurons first, then all output-layer neurons, and finally
// pulses done for one cycle.
//
// Ports
//   clk      sole clock, rising edge
//   rst      asynchronous active-high reset
//   clk_en   clock enable; nothing changes on an edge with clk_en = 0
//   start    request one full inference pass (only honoured in IDLE)
//   abort    cancel the current pass, back to IDLE with no write/done
//   bus      neuron_sequencer_if.master: neuron control + result write bus
//   busy     high in every state except IDLE
//   done     one-cycle pulse when the pass completes
//
// All outputs come straight from registers or are decoded from the
// registered state, so there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module neuron_sequencer #(
    parameter int n                    = 8,
    parameter int size_of_hidden_layer = 30,
    parameter int size_of_output_layer = 10,
    parameter int clog2_size_of_layer  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                start,
    input  logic                abort,
    neuron_sequencer_if.master  bus,
    output logic                busy,
    output logic                done
);

    localparam int W = clog2_size_of_layer;

    localparam logic [W-1:0] HID_LAST = W'(size_of_hidden_layer - 1);
    localparam logic [W-1:0] OUT_LAST = W'(size_of_output_layer - 1);
    localparam logic [W-1:0] IDX_ONE  = W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STORE,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic         sel_q, sel_d;
    logic [W-1:0] idx_q, idx_d;
    logic [n-1:0] data_q, data_d;
    logic [W-1:0] last_idx;

    // Index of the final neuron in whichever layer is being processed.
    assign last_idx = sel_q ? OUT_LAST : HID_LAST;

    // Next-state and datapath update. Abort from any active state wins over
    // every other transition; the index/layer registers are left alone on
    // abort because a fresh start clears them anyway.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        data_d  = data_q;

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        sel_d   = 1'b0;
                        idx_d   = '0;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (bus.neuron_ready) begin
                        data_d  = bus.neuron_result;
                        state_d = STORE;
                    end
                end
                STORE: begin
                    if (idx_q < last_idx) begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = LOAD;
                    end else if (!sel_q) begin
                        sel_d   = 1'b1;
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; they only move on enabled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Strobes are pure decodes of the registered state.
    assign bus.neuron_rst = (state_q == LOAD);
    assign bus.wr_en      = (state_q == STORE);
    assign done           = (state_q == DONE);
    assign busy           = (state_q != IDLE);

    assign bus.layer_sel  = sel_q;
    assign bus.neuron_idx = idx_q;
    assign bus.wr_layer   = sel_q;
    assign bus.wr_addr    = idx_q;
    assign bus.wr_data    = data_q;

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 SHALL have parameter n, default 8, width of one neuron result word.
REQ-002 SHALL have parameter size_of_hidden_layer, default 30, number of hidden-layer neurons.
REQ-003 SHALL have parameter size_of_output_layer, default 10, number of output-layer neurons.
REQ-004 SHALL have parameter clog2_size_of_layer, default 5, width of neuron_idx, covering the larger layer.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port clk_en  in  1  clock enable; no state, counter or register change when 0.
REQ-008 SHALL have port start  in  1  request one full inference pass.
REQ-009 SHALL have port abort  in  1  cancel the current pass.
REQ-010 SHALL have port neuron_ready  in  1  shared neuron finished accumulation.
REQ-011 SHALL have port neuron_result  in  n  shared neuron output word.
REQ-012 SHALL have port neuron_rst  out  1  clears the shared neuron accumulator.
REQ-013 SHALL have port layer_sel  out  1  0 = hidden layer, 1 = output layer; selects weight/bias/input source.
REQ-014 SHALL have port neuron_idx  out  clog2_size_of_layer  current neuron index within the layer.
REQ-015 SHALL have port wr_en  out  1  result write strobe.
REQ-016 SHALL have port wr_layer  out  1  layer of the result being written.
REQ-017 SHALL have port wr_addr  out  clog2_size_of_layer  index of the result being written.
REQ-018 SHALL have port wr_data  out  n  result word being written.
REQ-019 SHALL have port busy  out  1  high in every state except IDLE.
REQ-020 SHALL have port done  out  1  one-cycle pulse when the pass completes.

Function
REQ-021 SHALL implement states IDLE, LOAD, RUN, STORE, DONE; all transitions occur on an enabled edge (clk_en=1) only.
REQ-022 IDLE: on start=1 and abort=0, SHALL clear layer_sel and neuron_idx to 0 and go to LOAD; otherwise stay.
REQ-023 LOAD: SHALL assert neuron_rst for exactly that state, ignore neuron_ready, and go to RUN.
REQ-024 RUN: SHALL hold neuron_idx and layer_sel; neuron_ready=1 SHALL capture neuron_result into wr_data and go to STORE; otherwise stay.
REQ-025 STORE: SHALL assert wr_en for exactly that state, with wr_layer=layer_sel, wr_addr=neuron_idx, wr_data=captured word.
REQ-026 STORE advance: if neuron_idx < layer size-1, increment neuron_idx and go to LOAD.
REQ-027 STORE wrap: if layer_sel=0 and neuron_idx=size_of_hidden_layer-1, set layer_sel=1, neuron_idx=0, go to LOAD.
REQ-028 STORE final: if layer_sel=1 and neuron_idx=size_of_output_layer-1, go to DONE.
REQ-029 DONE: SHALL assert done for exactly that state and go to IDLE; start in DONE SHALL be ignored.
REQ-030 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-031 abort=1 in any non-IDLE state SHALL go to IDLE on that edge with no wr_en and no done; abort has priority over every other transition.
REQ-032 Per-neuron latency SHALL be 1 (LOAD) + k (RUN cycles up to and including the neuron_ready cycle) + 1 (STORE) enabled cycles; total pass = sum over 40 neurons + 1 (DONE).
REQ-033 neuron_idx SHALL never exceed the current layer size-1; no wrap through 2^width.
REQ-034 All outputs SHALL be driven from registers or decoded from the registered state only; no combinational path from inputs to outputs.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, layer_sel=0, neuron_idx=0, wr_data=0, and neuron_rst, wr_en, busy, done all 0, independent of clk and clk_en.
REQ-036 rst asserted mid-pass SHALL discard the pass; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-037 start pulse, neuron_ready after 3 RUN cycles each -> 40 wr_en pulses, hidden addrs 0..29 then output addrs 0..9, done once, pass length 40*5+1 = 201 cycles.
REQ-038 neuron_ready held high continuously -> each neuron takes 3 cycles; ready during LOAD is ignored; 40 writes, done after 121 cycles.
REQ-039 abort during RUN on hidden neuron 12 -> IDLE next cycle, no wr_en for neuron 12, no done; new start restarts at hidden 0.
REQ-040 clk_en=0 for 7 cycles mid-RUN with neuron_ready=1 -> no state/output change; STORE occurs on the first enabled ready edge.
REQ-041 rst pulsed asynchronously between edges during output neuron 5 -> all outputs 0 immediately; start pulses during busy and DONE produce no extra pass.
